// File: rtl/nn_sequencer.sv
// nn_sequencer: fetches MAC-array instructions and drives MAC, W, XY and serializer controls.
// Define SEQ_PERF_CNT_EN to add the perf_cycles / perf_stalls counters.
module nn_sequencer #(
  parameter int NU_COUNT   = 8,
  parameter int INST_DEPTH = 8,
  parameter int XY_DEPTH   = 10,
  parameter int W_DEPTH    = 10,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [INST_DEPTH-1:0] inst_addr,
  input  logic [31:0]           inst_data,
  output logic [NU_COUNT-1:0]   mac_reg_enable,
  output logic                  mac_acc_loopback,
  output logic                  mac_acc_update,
  output logic                  serializer_update,
  output logic [XY_DEPTH-1:0]   xy_read_addr,
  output logic [W_DEPTH-1:0]    w_read_addr,
  output logic [XY_DEPTH-1:0]   xy_write_addr,
  output logic                  xy_write_enable
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);

  // state | meaning
  // IDLE  | out of reset, waiting for start
  // FETCH | inst_addr=pc; instruction word arrives next cycle
  // EXEC  | decode, run beats or stall on the write-back drain
  // DONE  | halted or errored; start restarts at pc=0
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_MATMUL  = 4'd1;
  localparam logic [3:0] OP_ACCMOV  = 4'd2;
  localparam logic [3:0] OP_LOADMAC = 4'd3;
  localparam logic [3:0] OP_LOOP    = 4'd4;
  localparam logic [3:0] OP_ENDLOOP = 4'd5;
  localparam logic [3:0] OP_HALT    = 4'd6;
  localparam int WC_W = LEN_W + 1;

  state_t                state, state_nxt;
  logic [INST_DEPTH-1:0] pc, lstart;
  logic [LEN_W-1:0]      beat, lcnt;
  logic                  lactive;
  logic [WC_W-1:0]       wcnt;
  logic [XY_DEPTH-1:0]   waddr;

  logic [3:0]       op;
  logic [9:0]       fa, fb;
  logic [LEN_W-1:0] fc;
  logic start_acc, drain_busy, lmac_ok;
  logic exec_done, exec_err, stall, halt_go;

  assign op         = inst_data[31:28];
  assign fa         = inst_data[27:18];
  assign fb         = inst_data[17:8];
  assign fc         = inst_data[LEN_W-1:0];
  assign start_acc  = start && (state == S_IDLE || state == S_DONE);
  assign drain_busy = (wcnt != '0);
  assign lmac_ok    = int'(fb) < NU_COUNT;

  // Instruction outcome for the current EXEC cycle.
  always_comb begin
    exec_done = 1'b0;
    exec_err  = 1'b0;
    stall     = 1'b0;
    halt_go   = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        OP_NOP:     exec_done = 1'b1;
        OP_MATMUL:  exec_done = (beat == fc);
        OP_ACCMOV:  begin stall = drain_busy; exec_done = !drain_busy; end
        OP_LOADMAC: begin exec_err = !lmac_ok; exec_done = lmac_ok; end
        OP_LOOP:    begin exec_err = lactive; exec_done = !lactive; end
        OP_ENDLOOP: begin exec_err = !lactive; exec_done = lactive; end
        OP_HALT:    begin stall = drain_busy; halt_go = !drain_busy; end
        default:    exec_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_EXEC;
      S_EXEC: begin
        if (exec_err || halt_go) state_nxt = S_DONE;
        else if (exec_done)      state_nxt = S_FETCH;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // inst_addr is held through EXEC so a synchronous memory keeps presenting the word.
  always_comb begin
    busy              = (state == S_FETCH) || (state == S_EXEC);
    done              = (state == S_DONE);
    inst_addr         = ((state == S_FETCH) || (state == S_EXEC)) ? pc : '0;
    mac_reg_enable    = '0;
    mac_acc_loopback  = 1'b0;
    mac_acc_update    = 1'b0;
    serializer_update = 1'b0;
    xy_read_addr      = '0;
    w_read_addr       = '0;
    xy_write_enable   = drain_busy;
    xy_write_addr     = drain_busy ? waddr : '0;
    if (state == S_EXEC) begin
      case (op)
        OP_MATMUL: begin
          mac_acc_update   = 1'b1;
          mac_acc_loopback = (beat != '0);
          xy_read_addr     = XY_DEPTH'(fa) + XY_DEPTH'(beat);
          w_read_addr      = W_DEPTH'(fb) + W_DEPTH'(beat);
        end
        OP_ACCMOV: serializer_update = !drain_busy;
        OP_LOADMAC: begin
          if (lmac_ok) begin
            xy_read_addr = XY_DEPTH'(fa);
            for (int i = 0; i < NU_COUNT; i++) mac_reg_enable[i] = (int'(fb) == i);
          end
        end
        default: ;
      endcase
    end
  end

  // The write-back drain runs independently of the FSM; only reset discards it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      lstart  <= '0;
      beat    <= '0;
      lcnt    <= '0;
      lactive <= 1'b0;
      wcnt    <= '0;
      waddr   <= '0;
      err     <= 1'b0;
    end else begin
      if (drain_busy) begin
        wcnt  <= wcnt - WC_W'(1);
        waddr <= waddr + XY_DEPTH'(1);
      end
      if (start_acc) begin
        pc      <= '0;
        lstart  <= '0;
        beat    <= '0;
        lcnt    <= '0;
        lactive <= 1'b0;
        err     <= 1'b0;
      end else if (state == S_EXEC) begin
        if (exec_err) err <= 1'b1;
        if (exec_done) begin
          beat <= '0;
          pc   <= pc + INST_DEPTH'(1);
          case (op)
            OP_ACCMOV: begin
              wcnt  <= WC_W'(fc) + WC_W'(1);
              waddr <= XY_DEPTH'(fa);
            end
            OP_LOOP: begin
              lstart  <= pc + INST_DEPTH'(1);
              lcnt    <= fc;
              lactive <= 1'b1;
            end
            OP_ENDLOOP: begin
              if (lcnt != '0) begin
                lcnt <= lcnt - LEN_W'(1);
                pc   <= lstart;
              end else begin
                lactive <= 1'b0;
              end
            end
            default: ;
          endcase
        end else if (op == OP_MATMUL) begin
          beat <= beat + LEN_W'(1);
        end
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != '1)  perf_cycles <= perf_cycles + 32'd1;
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nn_sequencer.sv
// Bench for nn_sequencer: directed and random programs compared cycle by cycle
// against an instruction-level timing model.
module tb_nn_sequencer;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [7:0]  inst_addr;
  logic [31:0] inst_data = '0;
  logic [7:0]  mac_reg_enable;
  logic        mac_acc_loopback, mac_acc_update, serializer_update;
  logic [9:0]  xy_read_addr, w_read_addr, xy_write_addr;
  logic        xy_write_enable;

  nn_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .inst_addr(inst_addr), .inst_data(inst_data), .mac_reg_enable(mac_reg_enable),
    .mac_acc_loopback(mac_acc_loopback), .mac_acc_update(mac_acc_update),
    .serializer_update(serializer_update), .xy_read_addr(xy_read_addr),
    .w_read_addr(w_read_addr), .xy_write_addr(xy_write_addr),
    .xy_write_enable(xy_write_enable)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) inst_data <= mem[inst_addr];

  int n_checks = 0;
  int n_pass = 0;
  int e_busy[MAXC], e_done[MAXC], e_err[MAXC], e_ia[MAXC], e_en[MAXC], e_lb[MAXC];
  int e_upd[MAXC], e_ser[MAXC], e_xy[MAXC], e_w[MAXC], e_wa[MAXC], e_we[MAXC];
  int run_len;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic logic [31:0] enc(input int op, input int a, input int b, input int c);
    return {op[3:0], a[9:0], b[9:0], c[7:0]};
  endfunction

  function automatic logic [31:0] rand_instr();
    int r, a, b, c;
    r = $urandom_range(0, 19);
    a = $urandom_range(0, 1023);
    b = $urandom_range(0, 1023);
    c = $urandom_range(0, 7);
    if (r < 3)       return enc(0, a, b, $urandom_range(0, 255));
    else if (r < 9)  return enc(1, a, b, c);
    else if (r < 14) return enc(2, a, b, c);
    else if (r < 18) return enc(3, a, (r == 17) ? $urandom_range(0, 11) : $urandom_range(0, 7), c);
    else if (r == 18) return enc($urandom_range(7, 15), a, b, c);
    else             return enc(0, a, b, c);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = enc(6, 0, 0, 0);
  endtask

  task automatic gen_random();
    int n, nb, lp, use_loop, body;
    n = 0;
    clear_mem();
    nb = $urandom_range(3, 7);
    use_loop = $urandom_range(0, 1);
    lp = $urandom_range(0, nb - 1);
    for (int i = 0; i < nb; i++) begin
      if (use_loop != 0 && i == lp) begin
        mem[n] = enc(4, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3));
        n++;
        body = $urandom_range(1, 3);
        for (int j = 0; j < body; j++) begin mem[n] = rand_instr(); n++; end
        mem[n] = enc(5, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 255));
        n++;
      end
      mem[n] = rand_instr();
      n++;
    end
  endtask

  // Instruction-level model: FETCH+EXEC per instruction, drain tracked as the first free cycle.
  task automatic model_run();
    int t, pc, npc, lact, lcnt, lst, dfree, e, iss, nxt, op, a, b, c, fin, errf;
    logic [31:0] ins;
    t = 0; pc = 0; lact = 0; lcnt = 0; lst = 0; dfree = 0; fin = -1; errf = 0;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_ia[i] = 0; e_en[i] = 0; e_lb[i] = 0;
      e_upd[i] = 0; e_ser[i] = 0; e_xy[i] = 0; e_w[i] = 0; e_wa[i] = 0; e_we[i] = 0;
    end
    while (fin < 0 && t < MAXC - 300) begin
      ins = mem[pc];
      op = int'(ins[31:28]); a = int'(ins[27:18]); b = int'(ins[17:8]); c = int'(ins[7:0]);
      e = t + 1; nxt = e + 1; npc = (pc + 1) % 256;
      case (op)
        0: ;
        1: begin
          for (int k = 0; k <= c; k++) begin
            e_upd[e+k] = 1; e_lb[e+k] = (k != 0); e_xy[e+k] = (a + k) % 1024; e_w[e+k] = (b + k) % 1024;
          end
          nxt = e + c + 1;
        end
        2: begin
          iss = (e > dfree) ? e : dfree;
          e_ser[iss] = 1;
          for (int j = 0; j <= c; j++) begin e_we[iss+1+j] = 1; e_wa[iss+1+j] = (a + j) % 1024; end
          dfree = iss + c + 2;
          nxt = iss + 1;
        end
        3: if (b >= 8) begin errf = 1; fin = e + 1; end
           else begin e_en[e] = 1 << b; e_xy[e] = a; end
        4: if (lact != 0) begin errf = 1; fin = e + 1; end
           else begin lst = (pc + 1) % 256; lcnt = c; lact = 1; end
        5: if (lact == 0) begin errf = 1; fin = e + 1; end
           else if (lcnt > 0) begin lcnt--; npc = lst; end
           else lact = 0;
        6: fin = ((e > dfree) ? e : dfree) + 1;
        default: begin errf = 1; fin = e + 1; end
      endcase
      for (int k = t; k < ((fin >= 0) ? fin : nxt); k++) begin e_busy[k] = 1; e_ia[k] = pc; end
      pc = npc;
      t = nxt;
    end
    if (fin < 0) fin = t;
    for (int k = fin; k < MAXC; k++) begin e_done[k] = 1; e_err[k] = errf; end
    run_len = ((fin > dfree) ? fin : dfree) + 3;
  endtask

  task automatic check_cycle(input int cyc);
    chk("busy", cyc, 32'(busy), e_busy[cyc]);
    chk("done", cyc, 32'(done), e_done[cyc]);
    chk("err", cyc, 32'(err), e_err[cyc]);
    chk("inst_addr", cyc, 32'(inst_addr), e_ia[cyc]);
    chk("mac_reg_enable", cyc, 32'(mac_reg_enable), e_en[cyc]);
    chk("mac_acc_loopback", cyc, 32'(mac_acc_loopback), e_lb[cyc]);
    chk("mac_acc_update", cyc, 32'(mac_acc_update), e_upd[cyc]);
    chk("serializer_update", cyc, 32'(serializer_update), e_ser[cyc]);
    chk("xy_read_addr", cyc, 32'(xy_read_addr), e_xy[cyc]);
    chk("w_read_addr", cyc, 32'(w_read_addr), e_w[cyc]);
    chk("xy_write_addr", cyc, 32'(xy_write_addr), e_wa[cyc]);
    chk("xy_write_enable", cyc, 32'(xy_write_enable), e_we[cyc]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, -1, 32'(busy), 0);
    chk({tag, "_done"}, -1, 32'(done), 0);
    chk({tag, "_err"}, -1, 32'(err), 0);
    chk({tag, "_inst_addr"}, -1, 32'(inst_addr), 0);
    chk({tag, "_mac_reg_enable"}, -1, 32'(mac_reg_enable), 0);
    chk({tag, "_loopback"}, -1, 32'(mac_acc_loopback), 0);
    chk({tag, "_acc_update"}, -1, 32'(mac_acc_update), 0);
    chk({tag, "_ser_update"}, -1, 32'(serializer_update), 0);
    chk({tag, "_xy_read"}, -1, 32'(xy_read_addr), 0);
    chk({tag, "_w_read"}, -1, 32'(w_read_addr), 0);
    chk({tag, "_xy_write_addr"}, -1, 32'(xy_write_addr), 0);
    chk({tag, "_xy_write_en"}, -1, 32'(xy_write_enable), 0);
  endtask

  task automatic run_prog(input int inj, output int first_done, output int upd_cnt, output int we_cnt);
    model_run();
    first_done = -1; upd_cnt = 0; we_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < run_len; cyc++) begin
      @(negedge clk);
      check_cycle(cyc);
      if (done === 1'b1 && first_done < 0) first_done = cyc;
      if (mac_acc_update === 1'b1) upd_cnt++;
      if (xy_write_enable === 1'b1) we_cnt++;
      start = (cyc == inj && e_busy[cyc] != 0) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    int fd, uc, wc;
    clear_mem();
    #2 reset = 1'b0;
    #1 check_zero("in_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // MATMUL a=16 b=32 c=3 then HALT
    mem[0] = enc(1, 16, 32, 3);
    run_prog(-1, fd, uc, wc);
    chk("matmul_done_cycle", 0, fd, 7);
    chk("matmul_beats", 0, uc, 4);

    // ACCMOV drain overlapping the NOP fetch
    clear_mem();
    mem[0] = enc(2, 100, 0, 2); mem[1] = enc(0, 0, 0, 0);
    run_prog(-1, fd, uc, wc);
    chk("accmov_writes", 0, wc, 3);

    // second ACCMOV stalls behind the first drain
    clear_mem();
    mem[0] = enc(2, 7, 0, 5); mem[1] = enc(2, 0, 0, 0);
    run_prog(-1, fd, uc, wc);
    chk("accmov_stall_writes", 0, wc, 7);
    chk("accmov_stall_done_cycle", 0, fd, 11);

    // loop body runs c+1 times
    clear_mem();
    mem[0] = enc(4, 0, 0, 2); mem[1] = enc(1, 1, 2, 0); mem[2] = enc(5, 0, 0, 0);
    run_prog(-1, fd, uc, wc);
    chk("loop_beats", 0, uc, 3);
    chk("loop_err", 0, 32'(err), 0);

    // error programs: illegal opcode, LOADMAC out of range, nested LOOP, stray ENDLOOP
    for (int k = 0; k < 4; k++) begin
      clear_mem();
      case (k)
        0: mem[0] = enc(9, 0, 0, 0);
        1: begin mem[0] = enc(3, 33, 5, 0); mem[1] = enc(3, 12, 8, 0); end
        2: begin mem[0] = enc(4, 0, 0, 1); mem[1] = enc(4, 0, 0, 1); end
        default: mem[0] = enc(5, 0, 0, 0);
      endcase
      run_prog(-1, fd, uc, wc);
      chk("error_err", k, 32'(err), 1);
      chk("error_done", k, 32'(done), 1);
      chk("error_busy", k, 32'(busy), 0);
    end

    // address wrap at the top of XY/W space
    clear_mem();
    mem[0] = enc(1, 1022, 1023, 3); mem[1] = enc(2, 1022, 0, 3);
    run_prog(-1, fd, uc, wc);

    // reset in the middle of a MATMUL with a drain pending
    clear_mem();
    mem[0] = enc(2, 5, 0, 20); mem[1] = enc(1, 200, 300, 7);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("pre_reset_update", 4, 32'(mac_acc_update), 1);
    reset = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk); reset = 1'b1;
    run_prog(-1, fd, uc, wc);
    chk("rerun_beats", 0, uc, 8);
    chk("rerun_writes", 0, wc, 21);

    for (int r = 0; r < 30; r++) begin
      gen_random();
      run_prog($urandom_range(0, 20), fd, uc, wc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
